// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: captures source edges into PENDING, masks and prioritises them,
// and drives one processor interrupt line with a raise/ack handshake held until end-of-interrupt.
module irq_ctrl #(
  parameter logic [7:0]  BASE_ADDR = 8'hE0,
  parameter int unsigned N_SRC     = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  input  logic [N_SRC-1:0] SRC_IRQ,
  output logic [N_SRC-1:0] SRC_ACK,
  output logic             INT_RAISE,
  input  logic             INT_ACK
);

  localparam int unsigned IDX_W    = 3;
  localparam logic [1:0]  OFF_PEND = 2'd0;
  localparam logic [1:0]  OFF_MASK = 2'd1;
  localparam logic [1:0]  OFF_CAUS = 2'd2;
  localparam logic [1:0]  OFF_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RAISE   = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [7:0]       mask_q;
  logic [7:0]       cause_q, cause_d;
  logic             en_q;
  logic             raise_d;
  logic             rd_oe;
  logic [7:0]       rd_data;

  logic             in_range, rd_sel;
  logic             wr_pend, wr_mask, wr_ctrl, eoi_wr;
  logic [1:0]       off;
  logic [N_SRC-1:0] rise, req, w1c, eoi_clr;
  logic [IDX_W-1:0] hit_idx;
  logic [7:0]       rd_mux;

  // Bus decode: the block owns a 4-aligned window of addresses
  assign in_range = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign off      = BUS_ADDR[1:0];
  assign rd_sel   = in_range & ~BUS_WE;
  assign wr_pend  = in_range & BUS_WE & (off == OFF_PEND);
  assign wr_mask  = in_range & BUS_WE & (off == OFF_MASK);
  assign wr_ctrl  = in_range & BUS_WE & (off == OFF_CTRL);
  assign eoi_wr   = wr_ctrl & BUS_DATA[7];

  assign rise = SRC_IRQ & ~src_q;
  assign req  = pend_q & mask_q[N_SRC-1:0];
  assign w1c  = wr_pend ? BUS_DATA[N_SRC-1:0] : '0;

  // Lowest set index wins
  always_comb begin
    hit_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      OFF_PEND: rd_mux = 8'(pend_q);
      OFF_MASK: rd_mux = mask_q;
      OFF_CAUS: rd_mux = cause_q;
      OFF_CTRL: rd_mux = {7'b0, en_q};
      default:  rd_mux = 8'h00;
    endcase
  end

  // Dispatch FSM next-state and registered-output values
  always_comb begin
    state_d = state_q;
    raise_d = INT_RAISE;
    cause_d = cause_q;
    eoi_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (en_q && (req != '0)) begin
          cause_d = {1'b1, 4'b0, hit_idx};
          raise_d = 1'b1;
          state_d = S_RAISE;
        end
      end
      S_RAISE: begin
        if (INT_ACK) begin
          raise_d = 1'b0;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        raise_d = 1'b0;
        if (eoi_wr) begin
          eoi_clr    = N_SRC'(1) << cause_q[IDX_W-1:0];
          cause_d[7] = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        raise_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A new edge outranks a same-cycle clear
  assign pend_d = (pend_q & ~w1c & ~eoi_clr) | rise;

  // Source history keeps tracking through reset so a held level is not seen as a fresh edge
  always_ff @(posedge CLK) begin
    src_q <= SRC_IRQ;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      mask_q    <= 8'h00;
      cause_q   <= 8'h00;
      en_q      <= 1'b0;
      SRC_ACK   <= '0;
      INT_RAISE <= 1'b0;
      rd_oe     <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cause_q   <= cause_d;
      SRC_ACK   <= rise;
      INT_RAISE <= raise_d;
      rd_oe     <= rd_sel;
      rd_data   <= rd_mux;
      if (wr_mask) mask_q <= BUS_DATA;
      if (wr_ctrl) en_q <= BUS_DATA[0];
    end
  end

  assign BUS_DATA = rd_oe ? rd_data : 8'bz;

endmodule
